tdes_mode_sequencer: RTL and testbench

// Block-stream sequencer in front of the triple-DES cipher core. Buffers input blocks in a FIFO and

---
 rtl/tdes_mode_sequencer_if.sv | 29 ++
 rtl/tdes_mode_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_tdes_mode_sequencer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tdes_mode_sequencer_if.sv
// Stream and cipher-core bundle for the triple-DES mode sequencer.
// slave = sequencer side, master = environment (source, sink, core).
interface tdes_mode_sequencer_if #(
    parameter int BLOCK_W = 64
);
    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] out_data;
    logic               core_start;
    logic               core_encr_decr;
    logic [BLOCK_W-1:0] core_in;
    logic               core_done;
    logic [BLOCK_W-1:0] core_out;

    modport slave (
        input  in_valid, in_data, out_ready, core_done, core_out,
        output in_ready, out_valid, out_data,
        output core_start, core_encr_decr, core_in
    );

    modport master (
        output in_valid, in_data, out_ready, core_done, core_out,
        input  in_ready, out_valid, out_data,
        input  core_start, core_encr_decr, core_in
    );
endinterface

// File: rtl/tdes_mode_sequencer.sv
// FIFO-buffered ECB/CBC block sequencer in front of a triple-DES core.
// Optional WAIT-state watchdog enabled by defining TDES_TIMEOUT_EN.
module tdes_mode_sequencer #(
    parameter int BLOCK_W        = 64,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 128
) (
    input  logic               clk,
    input  logic               nrst,
    tdes_mode_sequencer_if.slave bus,
    input  logic               mode_cbc,
    input  logic               encr_decr,
    input  logic               iv_load,
    input  logic [BLOCK_W-1:0] iv,
    output logic               busy,
    output logic               err_timeout
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_OUT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [BLOCK_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;

    logic [BLOCK_W-1:0] r_chain;
    logic [BLOCK_W-1:0] r_cur;
    logic               r_cbc;
    logic               r_encr;
    logic [BLOCK_W-1:0] r_core_in;
    logic               r_core_ed;
    logic [BLOCK_W-1:0] r_out_data;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_iv_take;
    logic               w_done;
    logic               w_tmo;
    logic [BLOCK_W-1:0] w_head;
    logic               w_core_start;
    logic               w_out_valid;
    logic               w_busy;

    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = bus.in_valid & ~w_full;
    assign w_iv_take = (r_state == S_IDLE) & iv_load;
    // iv_load takes priority over launching the head block
    assign w_pop     = (r_state == S_IDLE) & ~w_empty & ~iv_load;
    assign w_done    = (r_state == S_WAIT) & bus.core_done;
    assign w_head    = r_mem[r_rptr];

    // FIFO storage and pointers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= bus.in_data;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_pop) w_next = S_START;
            end
            S_START: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (bus.core_done) w_next = S_OUT;
                else if (w_tmo)    w_next = S_IDLE;
            end
            S_OUT: begin
                if (bus.out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_core_start = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = ~w_empty;
        unique case (r_state)
            S_IDLE:  w_busy       = ~w_empty;
            S_START: begin
                w_core_start = 1'b1;
                w_busy       = 1'b1;
            end
            S_WAIT:  w_busy       = 1'b1;
            S_OUT: begin
                w_out_valid  = 1'b1;
                w_busy       = 1'b1;
            end
            default: w_busy       = 1'b1;
        endcase
    end

    // Launch capture and chaining datapath
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_chain    <= '0;
            r_cur      <= '0;
            r_cbc      <= 1'b0;
            r_encr     <= 1'b0;
            r_core_in  <= '0;
            r_core_ed  <= 1'b0;
            r_out_data <= '0;
        end else begin
            if (w_pop) begin
                r_cur     <= w_head;
                r_cbc     <= mode_cbc;
                r_encr    <= encr_decr;
                r_core_ed <= encr_decr;
                r_core_in <= (mode_cbc & encr_decr) ?
                             (w_head ^ r_chain) : w_head;
            end
            if (w_iv_take) begin
                r_chain <= iv;
            end else if (w_done) begin
                if (r_cbc & ~r_encr) begin
                    r_out_data <= bus.core_out ^ r_chain;
                    r_chain    <= r_cur;
                end else if (r_cbc) begin
                    r_out_data <= bus.core_out;
                    r_chain    <= bus.core_out;
                end else begin
                    r_out_data <= bus.core_out;
                end
            end
        end
    end

`ifdef TDES_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_err;

    assign w_tmo = (r_state == S_WAIT) & ~bus.core_done &
                   (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Abandoned block leaves chain untouched; flag stays until reset
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if ((r_state == S_WAIT) & ~bus.core_done & ~w_tmo) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end else begin
                r_tmo_cnt <= '0;
            end
            if (w_tmo) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_timeout = r_err;
`else
    assign w_tmo       = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign bus.in_ready       = ~w_full;
    assign bus.out_valid      = w_out_valid;
    assign bus.out_data       = r_out_data;
    assign bus.core_start     = w_core_start;
    assign bus.core_encr_decr = r_core_ed;
    assign bus.core_in        = r_core_in;
    assign busy               = w_busy;
endmodule

// File: tb/tb_tdes_mode_sequencer.sv
// Directed bench for tdes_mode_sequencer with an XOR-stub cipher core.
// Define TDES_TIMEOUT_EN to also exercise the watchdog path.
module tb_tdes_mode_sequencer;
    localparam logic [63:0] K = 64'hA5A5A5A5A5A5A5A5;

    logic        clk = 1'b0;
    logic        nrst;
    logic        mode_cbc;
    logic        encr_decr;
    logic        iv_load;
    logic [63:0] iv;
    logic        busy;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    logic        stub_en;
    logic        stub_act;
    int          stub_cnt;
    logic [63:0] stub_in;

    tdes_mode_sequencer_if #(.BLOCK_W(64)) bus ();

    tdes_mode_sequencer #(
        .BLOCK_W(64),
        .FIFO_DEPTH(4),
        .TIMEOUT_CYCLES(128)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .bus(bus),
        .mode_cbc(mode_cbc),
        .encr_decr(encr_decr),
        .iv_load(iv_load),
        .iv(iv),
        .busy(busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Core stub: result = in ^ K, done 48 cycles after start
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stub_act      <= 1'b0;
            stub_cnt      <= 0;
            stub_in       <= '0;
            bus.core_done <= 1'b0;
            bus.core_out  <= '0;
        end else begin
            bus.core_done <= 1'b0;
            if (bus.core_start && stub_en) begin
                stub_act <= 1'b1;
                stub_cnt <= 1;
                stub_in  <= bus.core_in;
            end else if (stub_act) begin
                if (stub_cnt == 47) begin
                    bus.core_done <= 1'b1;
                    bus.core_out  <= stub_in ^ K;
                    stub_act      <= 1'b0;
                end
                stub_cnt <= stub_cnt + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [63:0] d);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && n < 400) begin
            tick(1);
            n++;
        end
        tick(1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!bus.out_valid && n < 400) begin
            tick(1);
            n++;
        end
    endtask

    task automatic get_out(input string tag, input logic [63:0] exp);
        wait_out();
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check(tag, bus.out_data, exp);
        bus.out_ready = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
    endtask

    task automatic load_iv(input logic [63:0] v);
        iv      = v;
        iv_load = 1'b1;
        tick(1);
        iv_load = 1'b0;
    endtask

    initial begin
        nrst          = 1'b0;
        mode_cbc      = 1'b0;
        encr_decr     = 1'b1;
        iv_load       = 1'b0;
        iv            = '0;
        stub_en       = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_core_start", 64'(bus.core_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err_timeout), 64'd0);
        check("rst_out_data", bus.out_data, 64'd0);
        check("rst_core_in", bus.core_in, 64'd0);
        tick(3);
        nrst = 1'b1;
        tick(2);

        // ECB encrypt, launch timing and output hold
        push(64'h5368656C6C73686F);
        check("t1_no_start_yet", 64'(bus.core_start), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);
        tick(1);
        check("t1_core_start", 64'(bus.core_start), 64'd1);
        check("t1_core_in", bus.core_in, 64'h5368656C6C73686F);
        check("t1_core_ed", 64'(bus.core_encr_decr), 64'd1);
        tick(1);
        check("t1_start_pulse", 64'(bus.core_start), 64'd0);
        wait_out();
        tick(3);
        check("t1_hold_valid", 64'(bus.out_valid), 64'd1);
        check("t1_hold_data", bus.out_data, 64'hF6CDC0C9C9D6CDCA);
        get_out("t1_out", 64'hF6CDC0C9C9D6CDCA);
        check("t1_valid_drop", 64'(bus.out_valid), 64'd0);
        check("t1_idle", 64'(busy), 64'd0);

        // CBC encrypt
        mode_cbc  = 1'b1;
        encr_decr = 1'b1;
        load_iv(64'h1);
        push(64'h0);
        push(64'h0);
        get_out("t2_out0", 64'hA5A5A5A5A5A5A5A4);
        tick(2);
        check("t2_core_in1", bus.core_in, 64'hA5A5A5A5A5A5A5A4);
        get_out("t2_out1", 64'h0000000000000001);

        // CBC decrypt
        encr_decr = 1'b0;
        load_iv(64'h1);
        push(64'hA5A5A5A5A5A5A5A4);
        push(64'h0000000000000001);
        get_out("t3_out0", 64'h0);
        get_out("t3_out1", 64'h0);

        // Backpressure: 1 in flight + 4 buffered
        mode_cbc  = 1'b0;
        encr_decr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(64'h1000 + 64'(i));
        end
        check("t4_in_ready_full", 64'(bus.in_ready), 64'd0);
        check("t4_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 5; i++) begin
            get_out($sformatf("t4_out%0d", i), (64'h1000 + 64'(i)) ^ K);
        end
        tick(2);
        check("t4_drained_valid", 64'(bus.out_valid), 64'd0);
        check("t4_drained_busy", 64'(busy), 64'd0);

        // Async reset during WAIT
        push(64'hDEADBEEF00000000);
        push(64'h0123456789ABCDEF);
        tick(10);
        #2;
        nrst = 1'b0;
        #1;
        check("t5_out_valid", 64'(bus.out_valid), 64'd0);
        check("t5_core_start", 64'(bus.core_start), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_in_ready", 64'(bus.in_ready), 64'd1);
        check("t5_core_in", bus.core_in, 64'd0);
        check("t5_core_ed", 64'(bus.core_encr_decr), 64'd0);
        tick(2);
        nrst = 1'b1;
        tick(1);
        push(64'h0F0F0F0F0F0F0F0F);
        get_out("t5_after", 64'hAAAAAAAAAAAAAAAA);
        tick(2);
        check("t5_no_extra", 64'(bus.out_valid), 64'd0);

`ifdef TDES_TIMEOUT_EN
        // Watchdog abort with a silent core
        stub_en = 1'b0;
        push(64'h1234);
        begin
            int n;
            n = 0;
            while (!err_timeout && n < 400) begin
                tick(1);
                n++;
            end
            check("t6_cycles_in_range", 64'(n >= 120 && n <= 140), 64'd1);
        end
        check("t6_err", 64'(err_timeout), 64'd1);
        check("t6_out_valid", 64'(bus.out_valid), 64'd0);
        check("t6_idle", 64'(busy), 64'd0);
        stub_en = 1'b1;
        tick(5);
        check("t6_sticky", 64'(err_timeout), 64'd1);
`else
        check("t6_err_tied", 64'(err_timeout), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
